led_pattern_gen: RTL



---
 rtl/led_pattern_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern engine: COUNT, ROTATE, SCAN and BREATHE patterns advanced by a prescaled step.
// Optional LED_PAUSE_EN adds a pause input that freezes the prescaler and pattern.
module led_pattern_gen #(
  parameter int               NUM_LEDS    = 8,
  parameter int               DIV_W       = 24,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 24'd4_999_999,
  parameter int               PWM_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
`ifdef LED_PAUSE_EN
  input  logic                pause,
`endif
  input  logic [1:0]          mode,
  input  logic [DIV_W-1:0]    step_div,
  input  logic                mode_load,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step
);

  localparam logic [1:0] MODE_COUNT   = 2'd0;
  localparam logic [1:0] MODE_ROTATE  = 2'd1;
  localparam logic [1:0] MODE_SCAN    = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);
  localparam logic [PWM_W-1:0]    PWM_MAX = '1;

  logic [1:0]          mode_q, mode_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                step_q, step_d;
  logic [PWM_W-1:0]    duty_q, duty_d;
  logic                dir_q, dir_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic                pause_w;
  logic                step_ev;

`ifdef LED_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  always_comb begin
    step_ev   = (cnt_q == div_q) && !pause_w;
    mode_d    = mode_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    step_d    = step_ev;
    duty_d    = duty_q;
    dir_d     = dir_q;
    leds_d    = leds_q;
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

    if (!pause_w) begin
      cnt_d = step_ev ? '0 : cnt_q + DIV_W'(1);
    end

    if (step_ev) begin
      case (mode_q)
        MODE_COUNT:  leds_d = leds_q + LED_ONE;
        MODE_ROTATE: leds_d = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
        MODE_SCAN: begin
          if (dir_q == DIR_UP) begin
            leds_d = leds_q << 1;
            if (leds_d[NUM_LEDS-1]) dir_d = DIR_DOWN;
          end else begin
            leds_d = leds_q >> 1;
            if (leds_d[0]) dir_d = DIR_UP;
          end
        end
        default: begin
          if (dir_q == DIR_UP) begin
            duty_d = duty_q + PWM_W'(1);
            if (duty_d == PWM_MAX) dir_d = DIR_DOWN;
          end else begin
            duty_d = duty_q - PWM_W'(1);
            if (duty_d == '0) dir_d = DIR_UP;
          end
        end
      endcase
    end

    // Breathe drives the bank from the PWM compare every clock, independent of steps.
    if (mode_q == MODE_BREATHE) begin
      leds_d = {NUM_LEDS{pwm_cnt_q < duty_q}};
    end

    if (mode_load) begin
      mode_d = mode;
      div_d  = step_div;
      cnt_d  = '0;
      step_d = 1'b0;
      duty_d = '0;
      dir_d  = DIR_UP;
      leds_d = (mode == MODE_ROTATE || mode == MODE_SCAN) ? LED_ONE : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_COUNT;
      div_q     <= DEFAULT_DIV;
      cnt_q     <= '0;
      leds_q    <= '0;
      step_q    <= 1'b0;
      duty_q    <= '0;
      dir_q     <= DIR_UP;
      pwm_cnt_q <= '0;
    end else begin
      mode_q    <= mode_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      leds_q    <= leds_d;
      step_q    <= step_d;
      duty_q    <= duty_d;
      dir_q     <= dir_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign leds = leds_q;
  assign step = step_q;

endmodule
